// File: rtl/scoreboard_pkg.sv
// Shared scoreboard types: BCD score digits, winner encoding and score conversion.
// Used by both score_keeper and display_controller.
package scoreboard_pkg;

    localparam int DIGIT_W   = 4;
    localparam int MAX_SCORE = 99;
    localparam int SCORE_W   = 7;

    typedef logic [DIGIT_W-1:0] bcd_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t ones;
    } score_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_t;

    // Binary value of a BCD score, used for saturation and win comparisons.
    function automatic logic [SCORE_W-1:0] to_bin(score_t s);
        return SCORE_W'(s.tens) * SCORE_W'(10) + SCORE_W'(s.ones);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button path: a 2-FF synchronizer, a stability counter, and a
// one-cycle pulse on each accepted press (0->1 of the debounced level).
module btn_debounce #(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);

    logic       sync_q1;
    logic       sync_q2;
    logic       level;
    logic       level_d;
    logic [7:0] cnt;

    // NOTE: non-blocking assignments let the synchronizer stages shift by one per edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            // Any sample that agrees with the accepted level restarts the count.
            if (sync_q2 != level) begin
                if (cnt == 8'(DEBOUNCE_MS - 1)) begin
                    level <= sync_q2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end else begin
                cnt <= '0;
            end
            level_d <= level;
            press   <= level & ~level_d;
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Debounces the five player buttons, keeps two saturating BCD scores,
// pulses a per-player scoring event and locks increments once a match is won.
module score_keeper
    import scoreboard_pkg::*;
#(
    parameter int DEBOUNCE_MS = 20,
    parameter int WIN_SCORE   = 21,
    parameter int WIN_LEAD    = 2
) (
    input  logic               clk_1khz,
    input  logic               rst_ni,
    input  logic               p1_inc_i,
    input  logic               p1_dec_i,
    input  logic               p2_inc_i,
    input  logic               p2_dec_i,
    input  logic               clear_i,
    output logic [DIGIT_W-1:0] p1_tens_o,
    output logic [DIGIT_W-1:0] p1_ones_o,
    output logic [DIGIT_W-1:0] p2_tens_o,
    output logic [DIGIT_W-1:0] p2_ones_o,
    output logic [1:0]         score_evt_o,
    output logic [1:0]         winner_o
);

    localparam int NUM_BTN    = 5;
    localparam int BTN_P1_INC = 0;
    localparam int BTN_P1_DEC = 1;
    localparam int BTN_P2_INC = 2;
    localparam int BTN_P2_DEC = 3;
    localparam int BTN_CLEAR  = 4;

    logic [NUM_BTN-1:0] raw_btn;
    logic [NUM_BTN-1:0] press;
    score_t             p1, p2;
    score_t             p1_next, p2_next;
    logic               inc_en;
    logic [1:0]         score_evt;
    winner_t            winner;

    assign raw_btn = {clear_i, p2_dec_i, p2_inc_i, p1_dec_i, p1_inc_i};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_btn (
            .clk   (clk_1khz),
            .rst_n (rst_ni),
            .raw   (raw_btn[i]),
            .press (press[i])
        );
    end

    function automatic score_t bcd_inc(score_t s);
        score_t r = s;
        if (s.ones == 4'd9) begin
            r.ones = '0;
            r.tens = s.tens + 4'd1;
        end else begin
            r.ones = s.ones + 4'd1;
        end
        return r;
    endfunction

    function automatic score_t bcd_dec(score_t s);
        score_t r = s;
        if (s.ones == 4'd0) begin
            r.ones = 4'd9;
            r.tens = s.tens - 4'd1;
        end else begin
            r.ones = s.ones - 4'd1;
        end
        return r;
    endfunction

    // Opposing inc/dec in the same cycle cancel; both ends of the range saturate.
    function automatic score_t step(score_t s, logic inc, logic dec);
        if (inc && !dec && to_bin(s) != SCORE_W'(MAX_SCORE)) return bcd_inc(s);
        if (dec && !inc && to_bin(s) != '0) return bcd_dec(s);
        return s;
    endfunction

    function automatic logic wins(score_t me, score_t other);
        int a;
        int b;
        a = int'(to_bin(me));
        b = int'(to_bin(other));
        return (a >= WIN_SCORE) && (a - b >= WIN_LEAD);
    endfunction

    always_comb begin
        inc_en  = (winner == WIN_NONE);
        p1_next = step(p1, press[BTN_P1_INC] & inc_en, press[BTN_P1_DEC]);
        p2_next = step(p2, press[BTN_P2_INC] & inc_en, press[BTN_P2_DEC]);
    end

    // The winner follows the registered scores, so it trails a score change by one cycle.
    always_ff @(posedge clk_1khz or negedge rst_ni) begin
        if (!rst_ni) begin
            p1        <= '0;
            p2        <= '0;
            score_evt <= '0;
            winner    <= WIN_NONE;
        end else if (press[BTN_CLEAR]) begin
            p1        <= '0;
            p2        <= '0;
            score_evt <= '0;
            winner    <= WIN_NONE;
        end else begin
            p1        <= p1_next;
            p2        <= p2_next;
            score_evt <= {p2_next != p2, p1_next != p1};
            if (wins(p1, p2))      winner <= WIN_P1;
            else if (wins(p2, p1)) winner <= WIN_P2;
            else                   winner <= WIN_NONE;
        end
    end

    assign p1_tens_o   = p1.tens;
    assign p1_ones_o   = p1.ones;
    assign p2_tens_o   = p2.tens;
    assign p2_ones_o   = p2.ones;
    assign score_evt_o = score_evt;
    assign winner_o    = winner;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed scenarios plus random button
// transactions scored against an integer-arithmetic reference of the match rules.
module tb_score_keeper;

    localparam int D         = 4;
    localparam int WIN_SCORE = 21;
    localparam int WIN_LEAD  = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] btn;  // {clear, p2_dec, p2_inc, p1_dec, p1_inc}
    logic [3:0] p1_tens, p1_ones, p2_tens, p2_ones;
    logic [1:0] evt;
    logic [1:0] winner;

    int compared   = 0;
    int mismatched = 0;

    int m1 = 0;
    int m2 = 0;
    int exp_e1;
    int exp_e2;

    score_keeper #(.DEBOUNCE_MS(D), .WIN_SCORE(WIN_SCORE), .WIN_LEAD(WIN_LEAD)) dut (
        .clk_1khz    (clk),
        .rst_ni      (rst_n),
        .p1_inc_i    (btn[0]),
        .p1_dec_i    (btn[1]),
        .p2_inc_i    (btn[2]),
        .p2_dec_i    (btn[3]),
        .clear_i     (btn[4]),
        .p1_tens_o   (p1_tens),
        .p1_ones_o   (p1_ones),
        .p2_tens_o   (p2_tens),
        .p2_ones_o   (p2_ones),
        .score_evt_o (evt),
        .winner_o    (winner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [1:0] ref_winner(input int a, input int b);
        if (a >= WIN_SCORE && a - b >= WIN_LEAD) return 2'b01;
        if (b >= WIN_SCORE && b - a >= WIN_LEAD) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int ref_step(input int s, input logic inc, input logic dec);
        if (inc && !dec) return (s < 99) ? s + 1 : s;
        if (dec && !inc) return (s > 0) ? s - 1 : s;
        return s;
    endfunction

    // One accepted press of the buttons in m, applied to the reference scores.
    task automatic ref_apply(input logic [4:0] m);
        int  n1, n2;
        logic locked;
        locked = (ref_winner(m1, m2) != 2'b00);
        if (m[4]) begin
            m1 = 0;
            m2 = 0;
            return;
        end
        n1 = ref_step(m1, m[0] && !locked, m[1]);
        n2 = ref_step(m2, m[2] && !locked, m[3]);
        exp_e1 = (n1 != m1) ? 1 : 0;
        exp_e2 = (n2 != m2) ? 1 : 0;
        m1 = n1;
        m2 = n2;
    endtask

    // Hold mask for 'hold' cycles, release, let everything settle, then compare.
    task automatic do_press(input string tag, input logic [4:0] mask, input int hold);
        int c1 = 0;
        int c2 = 0;
        int cb = 0;
        int total = hold + D + 8;
        exp_e1 = 0;
        exp_e2 = 0;
        if (hold >= D) ref_apply(mask);
        btn = mask;
        for (int i = 0; i < total; i++) begin
            @(negedge clk);
            if (evt[0]) c1++;
            if (evt[1]) c2++;
            if (evt == 2'b11) cb++;
            if (i == hold - 1) btn = '0;
        end
        check({tag, "_p1"}, {24'd0, p1_tens, p1_ones}, {24'd0, bcd(m1)});
        check({tag, "_p2"}, {24'd0, p2_tens, p2_ones}, {24'd0, bcd(m2)});
        check({tag, "_win"}, {30'd0, winner}, {30'd0, ref_winner(m1, m2)});
        check({tag, "_evt1"}, c1, exp_e1);
        check({tag, "_evt2"}, c2, exp_e2);
        check({tag, "_evtboth"}, cb, (exp_e1 == 1 && exp_e2 == 1) ? 1 : 0);
    endtask

    initial begin
        int         r;
        int         h;
        logic [4:0] m;
        int         nz;

        rst_n = 1'b0;
        btn   = '0;
        #1;
        check("rst_scores", {16'd0, p1_tens, p1_ones, p2_tens, p2_ones}, 32'd0);
        check("rst_evt_win", {28'd0, evt, winner}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Latency of a held press and a single pulse while held.
        btn = 5'b00001;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 7) check("lat_before", {24'd0, p1_tens, p1_ones}, 32'h00);
            if (i == 8) begin
                check("lat_score", {24'd0, p1_tens, p1_ones}, 32'h01);
                check("lat_evt", {30'd0, evt}, 32'd1);
            end
            if (i == 9) check("lat_evt_end", {30'd0, evt}, 32'd0);
        end
        btn = '0;
        repeat (D + 8) @(negedge clk);
        m1 = 1;
        check("held_p1", {24'd0, p1_tens, p1_ones}, 32'h01);
        check("held_p2", {24'd0, p2_tens, p2_ones}, 32'h00);

        // Glitch one sample short of acceptance, then a press of exactly D samples.
        do_press("glitch", 5'b00001, D - 1);
        do_press("min_hold", 5'b00100, D);
        do_press("dec_p2", 5'b01000, D);

        // BCD carry and borrow, then saturation at zero.
        for (int i = 0; i < 10; i++) do_press("p2_up", 5'b00100, D + 1);
        do_press("p2_dec_borrow", 5'b01000, D + 1);
        for (int i = 0; i < 9; i++) do_press("p2_down", 5'b01000, D);
        do_press("p2_dec_sat", 5'b01000, D);

        // Win lock: 20/19, p1 wins at 21, p2 increments ignored, p1 correction unlocks.
        do_press("clear1", 5'b10000, D);
        for (int i = 0; i < 20; i++) do_press("pre_p1", 5'b00001, D);
        for (int i = 0; i < 19; i++) do_press("pre_p2", 5'b00100, D);
        do_press("win_p1", 5'b00001, D + 2);
        do_press("locked_p2", 5'b00100, D + 2);
        do_press("unlock_p1", 5'b00010, D + 2);

        // Simultaneous presses.
        do_press("both_inc", 5'b00101, D + 1);
        do_press("inc_dec_p1", 5'b00011, D + 1);
        do_press("clear_over", 5'b10001, D + 1);

        // Random transactions around the win region.
        for (int i = 0; i < 20; i++) do_press("warm_p1", 5'b00001, D);
        for (int i = 0; i < 18; i++) do_press("warm_p2", 5'b00100, D);
        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 19);
            h = D + $urandom_range(0, 5);
            if (r <= 6)       m = 5'b00001;
            else if (r <= 11) m = 5'b00100;
            else if (r <= 13) m = 5'b00010;
            else if (r <= 15) m = 5'b01000;
            else if (r == 16) m = 5'b00011;
            else if (r == 17) m = 5'b00101;
            else if (r == 18) m = ($urandom_range(0, 3) == 0) ? 5'b10000 : 5'b01100;
            else begin
                m = 5'b00001 << $urandom_range(0, 3);
                h = $urandom_range(1, D - 1);
            end
            do_press("rand", m, h);
        end

        // Reset in the middle of a debounce at 12/07.
        do_press("clear2", 5'b10000, D);
        for (int i = 0; i < 12; i++) do_press("to12", 5'b00001, D);
        for (int i = 0; i < 7; i++) do_press("to07", 5'b00100, D);
        check("pre_rst", {16'd0, p1_tens, p1_ones, p2_tens, p2_ones}, 32'h1207);
        btn = 5'b00001;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        btn   = '0;
        #1;
        check("async_rst_scores", {16'd0, p1_tens, p1_ones, p2_tens, p2_ones}, 32'd0);
        check("async_rst_evt_win", {28'd0, evt, winner}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m1 = 0;
        m2 = 0;
        nz = 0;
        repeat (D + 8) begin
            @(negedge clk);
            if (evt != 2'b00) nz++;
        end
        check("post_rst_evt", nz, 0);
        check("post_rst_scores", {16'd0, p1_tens, p1_ones, p2_tens, p2_ones}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
